// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, single-port data-memory handshake, branch
// resolution, and the MEM/WB register used by writeback and EX forwarding.
// Latency: EX -> EX/MEM one cycle, EX/MEM -> MEM/WB one more (+N for N memory wait cycles).
// Backpressure: MEM_stall freezes IF/ID/EX and EX/MEM while a load/store awaits dmem_ack.
//
// Optional feature macro: MEM_TIMEOUT_EN (abort a memory access after TIMEOUT_CYCLES
// WAIT cycles and pulse MEM_fault). Without it, WAIT holds until dmem_ack.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   EX_*                      instruction leaving EX (control, ALU result, store data)
//   EX_stall, flush           capture a bubble into EX/MEM instead of the EX instruction
//   EX_MEM_*                  registered EX/MEM fields exported for forwarding
//   MEM_stall                 pipeline freeze while memory is busy
//   MEM_mispredict            branch in EX/MEM resolved opposite to its prediction
//   MEM_fault                 one-cycle pulse when a memory access is aborted
//   dmem_*                    request/acknowledge data-memory interface
//   MEM_WB_*                  writeback register
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_stall,
    input  logic        flush,
    input  logic [31:0] EX_ALU_result,
    input  logic        EX_zero,
    input  logic [4:0]  EX_rd,
    input  logic        EX_branch,
    input  logic        EX_take,
    input  logic        EX_memread,
    input  logic        EX_memwrite,
    input  logic        EX_memtoreg,
    input  logic        EX_regwrite,
    input  logic [31:0] EX_rs2_data,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memtoreg,
    output logic        MEM_stall,
    output logic        MEM_mispredict,
    output logic        MEM_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_WB_regwrite
);

    // The wait counter only ever reaches TIMEOUT_CYCLES-1, so it must fit in CNT_W bits.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_params
        $error("mem_stage: TIMEOUT_CYCLES must be in 1..2**CNT_W");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // EX/MEM fields that are not exported as ports
    logic        ex_mem_zero;
    logic        ex_mem_branch;
    logic        ex_mem_take;
    logic        ex_mem_memread;
    logic        ex_mem_memwrite;
    logic [31:0] ex_mem_rs2_data;

    logic mem_op;
    logic bubble_in;
    logic timeout;

    assign mem_op    = ex_mem_memread | ex_mem_memwrite;
    assign bubble_in = EX_stall | flush;

    //------------------------------------------------------------------
    // EX/MEM register. A stall holds the current instruction in place,
    // which is why it wins over flush/EX_stall: the instruction being
    // squashed has simply not been accepted yet. Data fields are loaded
    // even for bubbles; only the control bits define a bubble.
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_MEM_ALU_result <= '0;
            EX_MEM_rd         <= '0;
            EX_MEM_regwrite   <= 1'b0;
            EX_MEM_memtoreg   <= 1'b0;
            ex_mem_zero       <= 1'b0;
            ex_mem_branch     <= 1'b0;
            ex_mem_take       <= 1'b0;
            ex_mem_memread    <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_rs2_data   <= '0;
        end else if (!MEM_stall) begin
            EX_MEM_ALU_result <= EX_ALU_result;
            EX_MEM_rd         <= EX_rd;
            ex_mem_zero       <= EX_zero;
            ex_mem_take       <= EX_take;
            ex_mem_rs2_data   <= EX_rs2_data;
            if (bubble_in) begin
                EX_MEM_regwrite <= 1'b0;
                EX_MEM_memtoreg <= 1'b0;
                ex_mem_branch   <= 1'b0;
                ex_mem_memread  <= 1'b0;
                ex_mem_memwrite <= 1'b0;
            end else begin
                EX_MEM_regwrite <= EX_regwrite;
                EX_MEM_memtoreg <= EX_memtoreg;
                ex_mem_branch   <= EX_branch;
                ex_mem_memread  <= EX_memread;
                ex_mem_memwrite <= EX_memwrite;
            end
        end
    end

    //------------------------------------------------------------------
    // Access timeout
    //------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles only; the first (IDLE) cycle of an access is not counted.
    assign timeout = (state_q == S_WAIT) && mem_op && !dmem_ack &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_q == S_WAIT) && !dmem_ack && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    //------------------------------------------------------------------
    // Handshake FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // !mem_op cannot normally occur here; it keeps the FSM from sticking.
                if (dmem_ack || timeout || !mem_op) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Combinational outputs. The request comes straight from EX/MEM so a
    // zero-wait memory can acknowledge in the cycle after capture, and the
    // request fields stay stable because EX/MEM is frozen while stalled.
    //------------------------------------------------------------------
    assign MEM_stall      = mem_op && !dmem_ack && !timeout;
    assign MEM_fault      = timeout;
    assign MEM_mispredict = ex_mem_branch && (ex_mem_zero != ex_mem_take);
    assign dmem_req       = mem_op;
    assign dmem_we        = ex_mem_memwrite;
    assign dmem_addr      = EX_MEM_ALU_result;
    assign dmem_wdata     = ex_mem_rs2_data;

    //------------------------------------------------------------------
    // MEM/WB register. Stalled or aborted accesses retire nothing; stores
    // never write the register file.
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_WB_rd       <= '0;
            MEM_WB_result   <= '0;
            MEM_WB_regwrite <= 1'b0;
        end else if (MEM_stall || timeout) begin
            MEM_WB_regwrite <= 1'b0;
        end else begin
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_regwrite <= EX_MEM_regwrite && !ex_mem_memwrite;
            MEM_WB_result   <= EX_MEM_memtoreg ? dmem_rdata : EX_MEM_ALU_result;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int TIMEOUT = 16;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_stall, flush;
    logic [31:0] EX_ALU_result;
    logic        EX_zero;
    logic [4:0]  EX_rd;
    logic        EX_branch, EX_take, EX_memread, EX_memwrite, EX_memtoreg, EX_regwrite;
    logic [31:0] EX_rs2_data;
    logic [31:0] EX_MEM_ALU_result;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite, EX_MEM_memtoreg;
    logic        MEM_stall, MEM_mispredict, MEM_fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_result;
    logic        MEM_WB_regwrite;

    mem_stage #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .EX_stall(EX_stall), .flush(flush),
        .EX_ALU_result(EX_ALU_result), .EX_zero(EX_zero), .EX_rd(EX_rd),
        .EX_branch(EX_branch), .EX_take(EX_take), .EX_memread(EX_memread),
        .EX_memwrite(EX_memwrite), .EX_memtoreg(EX_memtoreg), .EX_regwrite(EX_regwrite),
        .EX_rs2_data(EX_rs2_data), .EX_MEM_ALU_result(EX_MEM_ALU_result),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regwrite(EX_MEM_regwrite),
        .EX_MEM_memtoreg(EX_MEM_memtoreg), .MEM_stall(MEM_stall),
        .MEM_mispredict(MEM_mispredict), .MEM_fault(MEM_fault), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_regwrite(MEM_WB_regwrite)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [4:0]  rd;
        logic        br, take, mr, mw, m2r, rw;
        logic [31:0] wd;
    } ins_t;

    // Reference model: instruction sitting in EX/MEM, last retired instruction,
    // and how long the current memory request has been outstanding.
    ins_t        m_ex;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_res;
    logic        m_wb_rw;
    int          pend, lat, lat_sel;
    logic        rdata_fix_en;
    logic [31:0] rdata_fix;
    int          stall_seen, fault_seen, we_seen, misp_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick_lat();
        return (lat_sel >= 0) ? lat_sel : int'($urandom_range(0, 3));
    endfunction

    function automatic ins_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                input logic [31:0] wd, input logic br, input logic take,
                                input logic zero, input logic mr, input logic mw,
                                input logic m2r, input logic rw);
        ins_t r;
        r.alu = alu; r.rd = rd; r.wd = wd; r.br = br; r.take = take; r.zero = zero;
        r.mr = mr; r.mw = mw; r.m2r = m2r; r.rw = rw;
        return r;
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        int   k;
        k = int'($urandom_range(0, 3));
        r = mk($urandom, 5'($urandom), $urandom, 1'b0, 1'($urandom), 1'($urandom),
               1'b0, 1'b0, 1'b0, 1'b0);
        case (k)
            0: r.rw = 1'($urandom);
            1: begin r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; end
            2: begin r.mw = 1'b1; r.rw = 1'($urandom); end
            default: r.br = 1'b1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_wb_rd = '0; m_wb_res = '0; m_wb_rw = 1'b0;
        pend = 0; lat = pick_lat();
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input ins_t in, input logic st, input logic fl);
        logic        mem_op, ack_e, to_e, stall_e;
        logic [31:0] rdv;
        ins_t        nx;
        EX_ALU_result = in.alu; EX_zero = in.zero; EX_rd = in.rd; EX_branch = in.br;
        EX_take = in.take; EX_memread = in.mr; EX_memwrite = in.mw;
        EX_memtoreg = in.m2r; EX_regwrite = in.rw; EX_rs2_data = in.wd;
        EX_stall = st; flush = fl;
        mem_op = m_ex.mr | m_ex.mw;
        ack_e  = mem_op && (pend >= lat);
        rdv    = rdata_fix_en ? rdata_fix : $urandom;
        dmem_ack = ack_e; dmem_rdata = rdv;
        #4;
        to_e    = TO_EN && mem_op && !ack_e && (pend >= TIMEOUT);
        stall_e = mem_op && !ack_e && !to_e;
        chk("stall", MEM_stall, stall_e);
        chk("dmem_req", dmem_req, mem_op);
        chk("mispredict", MEM_mispredict, m_ex.br && (m_ex.zero != m_ex.take));
        chk("fault", MEM_fault, to_e);
        chk("ex_mem_regwrite", EX_MEM_regwrite, m_ex.rw);
        chk("ex_mem_memtoreg", EX_MEM_memtoreg, m_ex.m2r);
        if (m_ex.br | m_ex.mr | m_ex.mw | m_ex.rw | m_ex.m2r)
            chk("ex_mem_alu", EX_MEM_ALU_result, m_ex.alu);
        if (m_ex.rw) chk("ex_mem_rd", EX_MEM_rd, m_ex.rd);
        if (mem_op) begin
            chk("dmem_we", dmem_we, m_ex.mw);
            chk("dmem_addr", dmem_addr, m_ex.alu);
            if (m_ex.mw) chk("dmem_wdata", dmem_wdata, m_ex.wd);
        end
        chk("wb_regwrite", MEM_WB_regwrite, m_wb_rw);
        if (m_wb_rw) begin
            chk("wb_rd", MEM_WB_rd, m_wb_rd);
            chk("wb_result", MEM_WB_result, m_wb_res);
        end
        stall_seen += int'(MEM_stall === 1'b1);
        fault_seen += int'(MEM_fault === 1'b1);
        we_seen    += int'(dmem_req === 1'b1 && dmem_we === 1'b1);
        misp_seen  += int'(MEM_mispredict === 1'b1);
        @(posedge clk); #1;
        if (stall_e || to_e) begin
            m_wb_rw = 1'b0;
        end else begin
            m_wb_rd  = m_ex.rd;
            m_wb_rw  = m_ex.rw && !m_ex.mw;
            m_wb_res = m_ex.m2r ? rdv : m_ex.alu;
        end
        if (!stall_e) begin
            nx = in;
            if (st || fl) begin
                nx.br = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.m2r = 1'b0; nx.rw = 1'b0;
            end
            m_ex = nx;
        end
        if (mem_op && stall_e) pend++;
        else begin pend = 0; lat = pick_lat(); end
    endtask

    task automatic nop();
        cycle('0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; EX_stall = 0; flush = 0; EX_ALU_result = 0; EX_zero = 0; EX_rd = 0;
        EX_branch = 0; EX_take = 0; EX_memread = 0; EX_memwrite = 0; EX_memtoreg = 0;
        EX_regwrite = 0; EX_rs2_data = 0; dmem_rdata = 0; dmem_ack = 0;
        lat_sel = -1; rdata_fix_en = 1'b0; rdata_fix = '0;
        stall_seen = 0; fault_seen = 0; we_seen = 0; misp_seen = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_mem_alu", EX_MEM_ALU_result, 32'h0);
        chk("rst_ex_mem_rd", EX_MEM_rd, 32'h0);
        chk("rst_ex_mem_regwrite", EX_MEM_regwrite, 32'h0);
        chk("rst_ex_mem_memtoreg", EX_MEM_memtoreg, 32'h0);
        chk("rst_stall", MEM_stall, 32'h0);
        chk("rst_mispredict", MEM_mispredict, 32'h0);
        chk("rst_fault", MEM_fault, 32'h0);
        chk("rst_req", dmem_req, 32'h0);
        chk("rst_we", dmem_we, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wb_rd", MEM_WB_rd, 32'h0);
        chk("rst_wb_result", MEM_WB_result, 32'h0);
        chk("rst_wb_regwrite", MEM_WB_regwrite, 32'h0);
        rst = 1'b0;

        // ALU op: two cycles to MEM/WB
        cycle(mk(32'h1234, 5'd5, 32'h0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
        nop();
        chk("alu_wb_rd", MEM_WB_rd, 32'd5);
        chk("alu_wb_result", MEM_WB_result, 32'h1234);
        chk("alu_wb_regwrite", MEM_WB_regwrite, 32'h1);

        // Load with three wait cycles
        lat_sel = 3; rdata_fix_en = 1'b1; rdata_fix = 32'hDEADBEEF;
        cycle(mk(32'h40, 5'd7, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b0);
        stall_seen = 0;
        repeat (4) nop();
        chk("load_stall_cycles", stall_seen, 32'd3);
        chk("load_wb_result", MEM_WB_result, 32'hDEADBEEF);
        chk("load_wb_rd", MEM_WB_rd, 32'd7);

        // Zero-wait store with EX_regwrite set
        lat_sel = 0; rdata_fix_en = 1'b0;
        cycle(mk(32'h80, 5'd9, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0, 1), 1'b0, 1'b0);
        stall_seen = 0; we_seen = 0;
        nop();
        chk("store_wb_regwrite", MEM_WB_regwrite, 32'h0);
        nop();
        chk("store_we_cycles", we_seen, 32'd1);
        chk("store_stall_cycles", stall_seen, 32'd0);

        // Branch resolution
        misp_seen = 0;
        cycle(mk(32'h0, 5'd0, 32'h0, 1, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0);
        nop();
        chk("branch_mispredict", misp_seen, 32'd1);
        misp_seen = 0;
        cycle(mk(32'h0, 5'd0, 32'h0, 1, 1, 1, 0, 0, 0, 0), 1'b0, 1'b0);
        nop();
        chk("branch_correct", misp_seen, 32'd0);

        // Flush while stalled leaves EX/MEM alone; flush once released makes a bubble
        lat_sel = 2;
        cycle(mk(32'h100, 5'd3, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b0);
        cycle(mk(32'h200, 5'd4, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b1);
        chk("flush_held_addr", EX_MEM_ALU_result, 32'h100);
        cycle(mk(32'h200, 5'd4, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b1);
        cycle(mk(32'h200, 5'd4, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b1);
        chk("flush_bubble_req", dmem_req, 32'h0);
        chk("flush_bubble_regwrite", EX_MEM_regwrite, 32'h0);

        // Randomized traffic
        lat_sel = -1;
        for (int i = 0; i < 400; i++) begin
            cycle(rand_ins(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end
        repeat (5) nop();

        // Access that is never acknowledged
        lat_sel = 1000;
        cycle(mk(32'h300, 5'd9, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b0);
        stall_seen = 0; fault_seen = 0;
        repeat (24) nop();
        chk("noack_stall_cycles", stall_seen, TO_EN ? 32'd16 : 32'd24);
        chk("noack_fault_pulses", fault_seen, TO_EN ? 32'd1 : 32'd0);

        // Reset in the middle of a WAIT drops the request at once
        cycle(mk(32'h340, 5'd10, 32'h0, 0, 0, 0, 1, 0, 1, 1), 1'b0, 1'b0);
        nop();
        nop();
        #3;
        chk("pre_rst_req", dmem_req, 32'h1);
        rst = 1'b1;
        #1;
        chk("midwait_rst_req", dmem_req, 32'h0);
        chk("midwait_rst_stall", MEM_stall, 32'h0);
        chk("midwait_rst_wb_regwrite", MEM_WB_regwrite, 32'h0);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        lat_sel = -1;
        model_reset();
        cycle(mk(32'h55, 5'd12, 32'h0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
        nop();
        chk("post_rst_wb_result", MEM_WB_result, 32'h55);
        for (int i = 0; i < 60; i++) cycle(rand_ins(), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
